// File: rtl/store_buffer_pkg.sv
// Shared CPU constants for the store buffer: default depth, derived pointer/count
// widths, the data memory size, and the entry layout kept in the FIFO.
package store_buffer_pkg;

    localparam int unsigned DM_WORDS = 1024;
    localparam int unsigned SB_DEPTH = 4;
    localparam int unsigned SB_PTR_W = $clog2(SB_DEPTH);
    localparam int unsigned SB_CNT_W = SB_PTR_W + 1;

    // Address is held as a word index; byte-offset bits are dropped at enqueue.
    typedef struct packed {
        logic [29:0] word;
        logic [31:0] data;
        logic [31:0] pc4;
    } sb_entry_t;

    function automatic logic sb_word_match(input logic [29:0] word, input logic [31:0] addr);
        return word == addr[31:2];
    endfunction

endpackage

// File: rtl/store_buffer.sv
// Circular store FIFO between the M stage and data memory: drains one store per
// idle memory cycle, refuses stores when full, and forwards the newest match to loads.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_req,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [31:0] st_pc4,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    output logic        stall,
    output logic        ld_hit,
    output logic [31:0] ld_data,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [31:0] dm_pc4,
    output logic [4:0]  count,
    output logic        empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    sb_entry_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    logic               w_full;
    logic               w_enq;
    logic               w_drain;
    logic [PTR_W-1:0]   w_idx;
    logic               w_hit;
    logic [31:0]        w_fwd;
    sb_entry_t          w_head_ent;
    logic               w_unused_bits;

    assign w_unused_bits = ^{st_addr[1:0], ld_addr[1:0]};

    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_enq      = st_req & ~w_full;
    assign w_drain    = (r_count != '0) & ~ld_req;
    assign w_head_ent = r_mem[r_head];

    // Full is judged on the registered count, so a same-cycle drain does not admit the store.
    assign stall = st_req & w_full;

    assign dm_we    = w_drain;
    assign dm_addr  = w_drain ? {w_head_ent.word, 2'b00} : 32'd0;
    assign dm_wdata = w_drain ? w_head_ent.data : 32'd0;
    assign dm_pc4   = w_drain ? w_head_ent.pc4 : 32'd0;

    assign count = 5'(r_count);
    assign empty = (r_count == '0);

    // Walk oldest to newest so the last match wins; only ages below count are live.
    always_comb begin
        w_hit = 1'b0;
        w_fwd = 32'd0;
        w_idx = r_head;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PTR_W'(k);
            if ((CNT_W'(k) < r_count) && sb_word_match(r_mem[w_idx].word, ld_addr)) begin
                w_hit = 1'b1;
                w_fwd = r_mem[w_idx].data;
            end
        end
        if (!ld_req) begin
            w_hit = 1'b0;
            w_fwd = 32'd0;
        end
    end

    assign ld_hit  = w_hit;
    assign ld_data = w_fwd;

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_tail] <= '{word: st_addr[31:2], data: st_data, pc4: st_pc4};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_drain) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_enq, w_drain})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, meaning the number of store entries; it SHALL be a power of two, 2..16.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low; 0 clears all state immediately.
REQ-004 st_req  input  1  the M stage presents a word store this cycle.
REQ-005 st_addr  input  32  store byte address; bits [1:0] are ignored.
REQ-006 st_data  input  32  store data word.
REQ-007 st_pc4  input  32  PC+4 of the store instruction, carried with the entry.
REQ-008 ld_req  input  1  the M stage presents a word load this cycle.
REQ-009 ld_addr  input  32  load byte address; bits [1:0] are ignored.
REQ-010 stall  output  1  the store was not accepted; the pipeline holds M and earlier stages.
REQ-011 ld_hit  output  1  a buffered store matches ld_addr, and ld_data replaces the DM read data.
REQ-012 ld_data  output  32  the data of the newest matching buffered store; 0 when ld_hit=0.
REQ-013 dm_we  output  1  write strobe to the data memory.
REQ-014 dm_addr  output  32  write address to the data memory, taken from the head entry.
REQ-015 dm_wdata  output  32  write data to the data memory, taken from the head entry.
REQ-016 dm_pc4  output  32  the head entry's PC+4, passed to the memory write trace.
REQ-017 count  output  5  the number of occupied entries, 0..DEPTH.
REQ-018 empty  output  1  high when count==0.

Function
REQ-019 The buffer SHALL be a circular FIFO with head and tail pointers, each wrapping modulo DEPTH.
REQ-020 Full condition: count==DEPTH.
REQ-021 Enqueue: when st_req=1 and not full, the entry {addr, data, pc4} SHALL be written at the tail on the clock edge, and tail SHALL advance by one.
REQ-022 Store refused when full: stall SHALL be driven combinationally as st_req & full.
  - Nothing is enqueued that cycle.
  - A drain in the same cycle does not admit the store; the store is accepted the following cycle.
REQ-023 Drain condition: count>0 and ld_req=0. While it holds, dm_we=1 and dm_addr/dm_wdata/dm_pc4 SHALL show the head entry combinationally; head SHALL advance at the clock edge.
REQ-024 Load priority: when ld_req=1, dm_we SHALL be 0, because the memory port is reserved for the load.
REQ-025 Simultaneous enqueue and drain SHALL leave count unchanged; count SHALL never exceed DEPTH or go below 0.
REQ-026 Forwarding: ld_hit=1 iff ld_req=1 and some occupied entry has addr[31:2]==ld_addr[31:2].
  - ld_data SHALL be the data of the newest such entry, i.e. the match closest to the tail.
  - Forwarding is purely combinational, with 0-cycle latency.
REQ-027 A store presented in the same cycle as a load SHALL NOT be forwarded to that load. This case is unreachable in the pipeline and is defined only for verification.
REQ-028 Entries that are not occupied SHALL never produce a hit, even across pointer wrap.
REQ-029 Latency: a store accepted at edge N SHALL appear on dm_we no earlier than the cycle after edge N.
REQ-030 Order: stores SHALL reach the data memory in exactly their acceptance order.

Reset
REQ-031 On reset=0, head=0, tail=0 and count=0 SHALL hold immediately, asynchronously. As a result empty=1, dm_we=0, ld_hit=0 and stall=0.
REQ-032 Stores pending when reset asserts SHALL be discarded and never written to memory.
REQ-033 Entry payload storage needs no reset; outputs SHALL be 0 whenever count==0 or the qualifying condition is false.

Structure
REQ-034 DEPTH's default and the pointer/count widths (log2 DEPTH, log2 DEPTH + 1) SHALL live in the shared CPU constants file, next to the memory size constant.
REQ-035 No sub-module: the FIFO storage, the pointers and the priority match logic form a single module.

Verification
REQ-036 Reset mid-operation: enqueue 3 stores, then pull reset low -> count=0, empty=1, dm_we=0 in the same cycle; no write of those stores is ever seen.
REQ-037 Fill to full: 5 back-to-back stores with ld_req held at 1 (no drain), addresses 0x0..0x10 -> 4 stores accepted; stall=1 on the 5th; release ld_req -> the 5th store is accepted one cycle after the first drain.
REQ-038 In-order drain: stores (0x100, 0xA), (0x104, 0xB), then idle -> dm_we writes 0x100<=0xA and then 0x104<=0xB on consecutive cycles, and dm_pc4 matches each store's st_pc4.
REQ-039 Newest-match forward: stores (0x20, 0x11), (0x20, 0x22) buffered, then load 0x22 -> ld_hit=1, ld_data=0x22, dm_we=0 that cycle.
REQ-040 Wrap-around: 10 stores interleaved with drains so tail wraps twice -> every write is seen in order, and a load to a fully drained address gives ld_hit=0.
REQ-041 Simultaneous enqueue and drain at count=2 -> count remains 2, and the head entry is written.
